score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL expose parameter WIN_SCORE, default 11, meaning the binary score (legal range 1..79) that ends the game.
REQ-002 The block SHALL expose parameter LOCKOUT, default 4, meaning the number of clock cycles after a counted goal during which new goal edges are ignored (legal range 1..255).
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 goal_p1  input  1  level from the puck logic; each rising edge is one goal for player 1.
REQ-006 goal_p2  input  1  level from the puck logic; each rising edge is one goal for player 2.
REQ-007 p1_ones  output  4  player 1 score, BCD ones digit, 0..9.
REQ-008 p1_tens  output  3  player 1 score, BCD tens digit, 0..7.
REQ-009 p2_ones  output  4  player 2 score, BCD ones digit, 0..9.
REQ-010 p2_tens  output  3  player 2 score, BCD tens digit, 0..7.
REQ-011 game_over  output  1  high while state is OVER.
REQ-012 winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven.
REQ-013 serve  output  2  01 player 1 serves next, 10 player 2 serves next.
REQ-014 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Function
REQ-015 Edge detect: goal_px SHALL count as an edge when it is 1 at the current rising edge and its registered previous sample is 0.
REQ-016 The registered previous samples SHALL update every cycle in all states.
REQ-017 The state machine SHALL have three states: PLAY, HOLD and OVER.
REQ-018 PLAY, exactly one edge (p1 or p2): the scorer's BCD score SHALL increment at that same clock edge, and the new value SHALL be visible on the outputs after that edge (1-cycle latency from input sample).
REQ-019 PLAY, edges on both inputs in the same cycle: neither score SHALL change and the state SHALL remain PLAY.
REQ-020 BCD increment: if ones is 9, ones SHALL become 0 and tens SHALL increment by 1; otherwise ones SHALL increment by 1.
REQ-021 The tens digit SHALL never exceed 7, which WIN_SCORE <= 79 guarantees.
REQ-022 After an increment, serve SHALL be set to the non-scoring player on that same edge.
REQ-023 An increment that makes the scorer's score equal WIN_SCORE SHALL move the state to OVER, set game_over=1, and set winner to the scorer, all on that same edge.
REQ-024 Any other increment SHALL move the state to HOLD and load the lockout counter with LOCKOUT-1.
REQ-025 HOLD: all goal edges SHALL be ignored and the counter SHALL decrement each cycle.
REQ-026 HOLD: when the counter is 0, the state SHALL return to PLAY on the next edge, giving exactly LOCKOUT cycles spent in HOLD.
REQ-027 OVER: scores, winner and serve SHALL be frozen and all goal edges SHALL be ignored until rst.
REQ-028 A goal input held high SHALL count only once; a second goal requires a low sample followed by a high sample.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL set all score digits to 0, game_over to 0, winner to 00, serve to 01, state to PLAY, the lockout counter to 0, and both previous samples to 0.
REQ-030 rst SHALL take priority over all goal activity in the same cycle, and SHALL abort HOLD or OVER immediately.
REQ-031 A goal input already high at the first cycle after rst deasserts SHALL count as an edge.

Verification
REQ-032 Single goal: after reset, pulse goal_p1 high for 1 cycle -> p1 shows 0/1 the next cycle, serve=10, and goal_p1 pulses during the following 4 cycles leave p1 at 1.
REQ-033 BCD wrap: with WIN_SCORE=11, give p2 ten spaced goals -> p2_tens=1 and p2_ones=0, with game_over=0.
REQ-034 Win: continue to an 11th p2 goal -> p2 shows 1/1, game_over=1 and winner=10, and further goals on either input change nothing.
REQ-035 Simultaneous goals: rising edges on goal_p1 and goal_p2 in the same cycle in PLAY -> both scores are unchanged and state remains PLAY.
REQ-036 Held input: hold goal_p1 high for 20 cycles -> p1 increments exactly once.
REQ-037 Reset in progress: assert rst during HOLD and during OVER -> all outputs return to reset values the next cycle, and a goal edge 1 cycle after release is counted.

Source files
------------

// File: rtl/score_keeper_if.sv
// ============================================================================
//  Module      : score_keeper_if
//  Description : Goal inputs and score/status outputs of the score keeper,
//                bundled with master (puck logic / display side) and slave
//                (score keeper) views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_keeper_if;
    logic       goal_p1;
    logic       goal_p2;
    logic [3:0] p1_ones;
    logic [2:0] p1_tens;
    logic [3:0] p2_ones;
    logic [2:0] p2_tens;
    logic       game_over;
    logic [1:0] winner;
    logic [1:0] serve;

    // Puck logic drives the goal levels and observes the scoreboard.
    modport master (
        output goal_p1, goal_p2,
        input  p1_ones, p1_tens, p2_ones, p2_tens, game_over, winner, serve
    );

    // Score keeper consumes the goal levels and drives the scoreboard.
    modport slave (
        input  goal_p1, goal_p2,
        output p1_ones, p1_tens, p2_ones, p2_tens, game_over, winner, serve
    );
endinterface

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
//  Module      : score_keeper
//  Description : Two-player BCD score keeper. Counts rising edges of the goal
//                levels, applies a post-goal lockout, tracks the server and
//                freezes the board once a player reaches WIN_SCORE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int WIN_SCORE = 11,   // 1..79, binary score that ends the game
    parameter int LOCKOUT   = 4     // 1..255, cycles of goal blanking after a goal
) (
    input  wire logic     clk,
    input  wire logic     rst,
    score_keeper_if.slave sk
);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HOLD = 2'd1,
        S_OVER = 2'd2
    } state_t;

    // Winning score expressed as BCD so it compares directly with the digits.
    localparam logic [3:0] c_win_ones  = 4'(WIN_SCORE % 10);
    localparam logic [2:0] c_win_tens  = 3'(WIN_SCORE / 10);
    localparam logic [6:0] c_win_bcd   = {c_win_tens, c_win_ones};
    localparam logic [7:0] c_lock_load = 8'(LOCKOUT - 1);

    state_t     r_state;
    logic       r_prev_p1;
    logic       r_prev_p2;
    logic [7:0] r_lock_cnt;
    logic [3:0] r_p1_ones;
    logic [2:0] r_p1_tens;
    logic [3:0] r_p2_ones;
    logic [2:0] r_p2_tens;
    logic       r_game_over;
    logic [1:0] r_winner;
    logic [1:0] r_serve;

    logic       w_edge_p1;
    logic       w_edge_p2;
    logic [6:0] w_p1_next;
    logic [6:0] w_p2_next;

    // BCD increment of a {tens, ones} pair; tens never passes 7 for legal WIN_SCORE.
    function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            bcd_inc = {tens + 3'd1, 4'd0};
        end else begin
            bcd_inc = {tens, ones + 4'd1};
        end
    endfunction

    // Rising-edge detection against the previous registered sample, plus the
    // candidate incremented score for each player.
    always_comb begin
        w_edge_p1 = sk.goal_p1 & ~r_prev_p1;
        w_edge_p2 = sk.goal_p2 & ~r_prev_p2;
        w_p1_next = bcd_inc(r_p1_tens, r_p1_ones);
        w_p2_next = bcd_inc(r_p2_tens, r_p2_ones);
    end

    // Game state machine: scoring, lockout countdown and end-of-game freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_PLAY;
            r_prev_p1   <= 1'b0;
            r_prev_p2   <= 1'b0;
            r_lock_cnt  <= 8'd0;
            r_p1_ones   <= 4'd0;
            r_p1_tens   <= 3'd0;
            r_p2_ones   <= 4'd0;
            r_p2_tens   <= 3'd0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_serve     <= 2'b01;
        end else begin
            // Previous samples track the inputs in every state so a level held
            // across HOLD/OVER cannot produce a late edge.
            r_prev_p1 <= sk.goal_p1;
            r_prev_p2 <= sk.goal_p2;

            case (r_state)
                S_PLAY: begin
                    // Simultaneous edges cancel: nobody scores.
                    if (w_edge_p1 && !w_edge_p2) begin
                        {r_p1_tens, r_p1_ones} <= w_p1_next;
                        r_serve                <= 2'b10;
                        if (w_p1_next == c_win_bcd) begin
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= 2'b01;
                        end else begin
                            r_state    <= S_HOLD;
                            r_lock_cnt <= c_lock_load;
                        end
                    end else if (w_edge_p2 && !w_edge_p1) begin
                        {r_p2_tens, r_p2_ones} <= w_p2_next;
                        r_serve                <= 2'b01;
                        if (w_p2_next == c_win_bcd) begin
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= 2'b10;
                        end else begin
                            r_state    <= S_HOLD;
                            r_lock_cnt <= c_lock_load;
                        end
                    end
                end
                S_HOLD: begin
                    // Counter is loaded with LOCKOUT-1, so HOLD lasts LOCKOUT cycles.
                    if (r_lock_cnt == 8'd0) begin
                        r_state <= S_PLAY;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 8'd1;
                    end
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_PLAY;
                end
            endcase
        end
    end

    assign sk.p1_ones   = r_p1_ones;
    assign sk.p1_tens   = r_p1_tens;
    assign sk.p2_ones   = r_p2_ones;
    assign sk.p2_tens   = r_p2_tens;
    assign sk.game_over = r_game_over;
    assign sk.winner    = r_winner;
    assign sk.serve     = r_serve;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Directed self-checking bench for score_keeper
//                (WIN_SCORE=11, LOCKOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    logic clk;
    logic rst;
    int   r_checks;
    int   r_errors;

    score_keeper_if sk_if ();

    score_keeper #(
        .WIN_SCORE (11),
        .LOCKOUT   (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .sk  (sk_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input int got, input int exp);
        r_checks++;
        if (got != exp) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One spaced goal: a single-cycle high pulse, then low long enough to clear HOLD.
    task automatic goal(input int player);
        if (player == 1) sk_if.goal_p1 = 1'b1;
        else             sk_if.goal_p2 = 1'b1;
        tick(1);
        sk_if.goal_p1 = 1'b0;
        sk_if.goal_p2 = 1'b0;
        tick(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".p1"},        {sk_if.p1_tens, sk_if.p1_ones}, 0);
        check({tag, ".p2"},        {sk_if.p2_tens, sk_if.p2_ones}, 0);
        check({tag, ".game_over"}, sk_if.game_over, 0);
        check({tag, ".winner"},    sk_if.winner, 0);
        check({tag, ".serve"},     sk_if.serve, 1);
    endtask

    initial begin
        r_checks      = 0;
        r_errors      = 0;
        rst           = 1'b1;
        sk_if.goal_p1 = 1'b0;
        sk_if.goal_p2 = 1'b0;
        tick(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(1);

        // Single goal for p1 followed by pulses inside the 4-cycle lockout.
        sk_if.goal_p1 = 1'b1;
        tick(1);
        check("single.p1_ones", sk_if.p1_ones, 1);
        check("single.p1_tens", sk_if.p1_tens, 0);
        check("single.serve",   sk_if.serve, 2);
        sk_if.goal_p1 = 1'b0; tick(1);
        sk_if.goal_p1 = 1'b1; tick(1);
        sk_if.goal_p1 = 1'b0; tick(1);
        sk_if.goal_p1 = 1'b1; tick(1);
        sk_if.goal_p1 = 1'b0;
        check("lockout.p1_ones", sk_if.p1_ones, 1);
        tick(2);
        check("lockout.p1_final", sk_if.p1_ones, 1);

        // Simultaneous edges in PLAY: nothing changes and PLAY persists.
        sk_if.goal_p1 = 1'b1;
        sk_if.goal_p2 = 1'b1;
        tick(1);
        check("simul.p1",    {sk_if.p1_tens, sk_if.p1_ones}, 1);
        check("simul.p2",    {sk_if.p2_tens, sk_if.p2_ones}, 0);
        check("simul.serve", sk_if.serve, 2);
        sk_if.goal_p1 = 1'b0;
        sk_if.goal_p2 = 1'b0;
        tick(1);
        // Still in PLAY: the very next p2 edge counts immediately.
        sk_if.goal_p2 = 1'b1;
        tick(1);
        check("simul.play_p2", sk_if.p2_ones, 1);
        check("simul.play_serve", sk_if.serve, 1);
        sk_if.goal_p2 = 1'b0;
        tick(5);

        // Nine more p2 goals: 10 total, BCD wrap to 1/0.
        for (int g = 0; g < 9; g++) goal(2);
        check("wrap.p2_tens",   sk_if.p2_tens, 1);
        check("wrap.p2_ones",   sk_if.p2_ones, 0);
        check("wrap.game_over", sk_if.game_over, 0);

        // Held input counts once.
        sk_if.goal_p1 = 1'b1;
        tick(20);
        sk_if.goal_p1 = 1'b0;
        check("held.p1", {sk_if.p1_tens, sk_if.p1_ones}, 2);
        tick(5);

        // 11th p2 goal wins.
        sk_if.goal_p2 = 1'b1;
        tick(1);
        sk_if.goal_p2 = 1'b0;
        check("win.p2_tens",   sk_if.p2_tens, 1);
        check("win.p2_ones",   sk_if.p2_ones, 1);
        check("win.game_over", sk_if.game_over, 1);
        check("win.winner",    sk_if.winner, 2);
        check("win.serve",     sk_if.serve, 1);
        tick(2);
        for (int k = 0; k < 3; k++) begin
            goal(1);
            goal(2);
        end
        check("over.p1",        {sk_if.p1_tens, sk_if.p1_ones}, 2);
        check("over.p2",        {sk_if.p2_tens, sk_if.p2_ones}, {3'd1, 4'd1});
        check("over.game_over", sk_if.game_over, 1);
        check("over.winner",    sk_if.winner, 2);
        check("over.serve",     sk_if.serve, 1);

        // Reset during OVER with a goal active; goal already high after release counts.
        rst           = 1'b1;
        sk_if.goal_p1 = 1'b1;
        tick(1);
        check_reset_outputs("rst_over");
        rst = 1'b0;
        tick(1);
        check("rst_over.p1_after", sk_if.p1_ones, 1);
        check("rst_over.serve",    sk_if.serve, 2);
        sk_if.goal_p1 = 1'b0;

        // Now in HOLD: reset aborts it, and a p2 edge right after release counts.
        tick(1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("rst_hold");
        rst           = 1'b0;
        sk_if.goal_p2 = 1'b1;
        tick(1);
        check("rst_hold.p2_after", sk_if.p2_ones, 1);
        check("rst_hold.serve",    sk_if.serve, 1);
        sk_if.goal_p2 = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire
